// File: rtl/ptcalc_mul_pkg.sv
// Shared constants and arithmetic helpers for the pipelined pt-calc multiplier.
package ptcalc_mul_pkg;

  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 6;

  // Working width for the narrowing helper; comfortably wider than any product plus rounding carry.
  localparam int NARROW_W = 128;

  typedef struct packed {
    logic [NARROW_W-1:0] p;
    logic                ovf;
  } narrow_t;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // value must already be sign- or zero-extended to NARROW_W according to is_signed.
  function automatic narrow_t round_shift_sat(input logic signed [NARROW_W-1:0] value,
                                              input int shift, input int out_w,
                                              input bit is_signed, input bit sat, input bit rnd);
    logic signed [NARROW_W-1:0] v, one, hi, lo, back;
    narrow_t r;
    one = {{(NARROW_W-1){1'b0}}, 1'b1};
    v   = value;
    if (rnd && shift > 0) v = v + (one <<< (shift - 1));
    v = v >>> shift;
    if (is_signed) begin
      hi = (one <<< (out_w - 1)) - one;
      lo = -(one <<< (out_w - 1));
    end else begin
      hi = (one <<< out_w) - one;
      lo = '0;
    end
    r.p   = v;
    r.ovf = 1'b0;
    if (sat) begin
      if (v > hi) begin
        r.p   = hi;
        r.ovf = 1'b1;
      end else if (v < lo) begin
        r.p   = lo;
        r.ovf = 1'b1;
      end
    end else begin
      // Wrap flags overflow when re-extending the kept bits does not reproduce v.
      if (is_signed) back = (v <<< (NARROW_W - out_w)) >>> (NARROW_W - out_w);
      else           back = $signed($unsigned(v <<< (NARROW_W - out_w)) >> (NARROW_W - out_w));
      r.ovf = (back != v);
    end
    return r;
  endfunction

endpackage

// File: rtl/ptcalc_mul_pipe_if.sv
// Valid/ready sample bus for ptcalc_mul_pipe: operand/tag in, narrowed product/tag/overflow out.
interface ptcalc_mul_pipe_if #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int OUT_W = 31,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_p;
  logic [TAG_W-1:0] out_tag;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag, out_ovf
  );
endinterface

// File: rtl/ptcalc_mul_narrow.sv
// Combinational round / shift / saturate-or-wrap of a full-precision product.
module ptcalc_mul_narrow
  import ptcalc_mul_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 31,
  parameter int SHIFT  = 0,
  parameter int SIGNED = 0,
  parameter int ROUND  = 0,
  parameter int SAT    = 1
) (
  input  logic [IN_W-1:0]  prod,
  output logic [OUT_W-1:0] p,
  output logic             ovf
);

    logic signed [NARROW_W-1:0] prod_ext;
    narrow_t                    res;
    logic [NARROW_W-OUT_W-1:0]  p_unused;

    assign prod_ext = {{(NARROW_W-IN_W){(SIGNED != 0) & prod[IN_W-1]}}, prod};

    always_comb begin
        res = round_shift_sat(prod_ext, SHIFT, OUT_W, SIGNED != 0, SAT != 0, ROUND != 0);
    end

    assign {p_unused, p} = res.p;
    assign ovf           = res.ovf;

endmodule

// File: rtl/ptcalc_mul_pipe.sv
// Pipelined A_W x B_W multiplier with stall-able valid/ready handshake and tag side-channel.
module ptcalc_mul_pipe
  import ptcalc_mul_pkg::*;
#(
  parameter int A_W       = 16,
  parameter int B_W       = 16,
  parameter int OUT_W     = 31,
  parameter int SHIFT     = 0,
  parameter int NUM_STAGE = 3,
  parameter int SIGNED    = 0,
  parameter int ROUND     = 0,
  parameter int SAT       = 1,
  parameter int TAG_W     = 8
) (
  input logic              ap_clk,
  input logic              ap_rst_n,
  ptcalc_mul_pipe_if.slave bus
);

    localparam int PW = prod_width(A_W, B_W);
    localparam int NS = (NUM_STAGE < NUM_STAGE_MIN) ? NUM_STAGE_MIN :
                        (NUM_STAGE > NUM_STAGE_MAX) ? NUM_STAGE_MAX : NUM_STAGE;

    logic             advance;
    logic [PW-1:0]    prod_c;
    logic [PW-1:0]    fin_prod;
    logic [TAG_W-1:0] fin_tag;
    logic             fin_vld;
    logic [OUT_W-1:0] fin_p;
    logic             fin_ovf;
    logic             vld_out;
    logic [OUT_W-1:0] p_out;
    logic [TAG_W-1:0] tag_out;
    logic             ovf_out;

    // The whole pipe moves as one; any stage may hold a bubble while the output stalls.
    assign advance      = !vld_out || bus.out_ready;
    assign bus.in_ready = advance;

    // Stage 0: full-precision multiply
    if (SIGNED != 0) begin : g_smul
        assign prod_c = PW'($signed(bus.in_a)) * PW'($signed(bus.in_b));
    end else begin : g_umul
        assign prod_c = PW'(bus.in_a) * PW'(bus.in_b);
    end

    if (NS == 1) begin : g_single
        assign fin_prod = prod_c;
        assign fin_tag  = bus.in_tag;
        assign fin_vld  = bus.in_valid;
    end else begin : g_multi
        localparam int NI = NS - 1;
        logic [PW-1:0]    prod_p [NI];
        logic [TAG_W-1:0] tag_p  [NI];
        logic             vld_p  [NI];

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                for (int i = 0; i < NI; i++) vld_p[i] <= 1'b0;
            end else if (advance) begin
                vld_p[0] <= bus.in_valid;
                for (int i = 1; i < NI; i++) vld_p[i] <= vld_p[i-1];
            end
        end

        // Stages 1..NS-2: register-only, left free for retiming into the DSP
        always_ff @(posedge ap_clk) begin
            if (advance) begin
                prod_p[0] <= prod_c;
                tag_p[0]  <= bus.in_tag;
                for (int i = 1; i < NI; i++) begin
                    prod_p[i] <= prod_p[i-1];
                    tag_p[i]  <= tag_p[i-1];
                end
            end
        end

        assign fin_prod = prod_p[NI-1];
        assign fin_tag  = tag_p[NI-1];
        assign fin_vld  = vld_p[NI-1];
    end

    // Final stage: round / shift / narrow into the output register
    ptcalc_mul_narrow #(
        .IN_W  (PW),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .SIGNED(SIGNED),
        .ROUND (ROUND),
        .SAT   (SAT)
    ) u_narrow (
        .prod(fin_prod),
        .p   (fin_p),
        .ovf (fin_ovf)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_out <= 1'b0;
            p_out   <= '0;
            tag_out <= '0;
            ovf_out <= 1'b0;
        end else if (advance) begin
            vld_out <= fin_vld;
            p_out   <= fin_p;
            tag_out <= fin_tag;
            ovf_out <= fin_ovf;
        end
    end

    assign bus.out_valid = vld_out;
    assign bus.out_p     = p_out;
    assign bus.out_tag   = tag_out;
    assign bus.out_ovf   = ovf_out;

endmodule

// File: tb/tb_ptcalc_mul_pipe.sv
// Bench for ptcalc_mul_pipe: six parameterisations fed one shared stream, checked against an arithmetic model.
module tb_ptcalc_mul_pipe;

    localparam int ND = 6;
    localparam int AW_T [ND] = '{16, 16,  8, 16, 16, 16};
    localparam int BW_T [ND] = '{16, 16,  8, 16, 16, 16};
    localparam int OW_T [ND] = '{31, 31, 16, 20, 12, 10};
    localparam int SH_T [ND] = '{ 0,  0,  0,  4,  4,  3};
    localparam int NS_T [ND] = '{ 3,  3,  2,  1,  4,  6};
    localparam int SG_T [ND] = '{ 0,  0,  1,  0,  1,  1};
    localparam int RD_T [ND] = '{ 0,  0,  0,  1,  0,  1};
    localparam int SA_T [ND] = '{ 1,  0,  1,  1,  1,  0};

    typedef struct packed {
        logic [31:0] p;
        logic        ovf;
        logic [7:0]  tag;
    } exp_t;

    logic        ap_clk    = 1'b0;
    logic        ap_rst_n  = 1'b1;
    logic        in_valid  = 1'b0;
    logic [15:0] in_a      = '0;
    logic [15:0] in_b      = '0;
    logic [7:0]  in_tag    = '0;
    logic        out_ready = 1'b1;
    int          rdy_mode  = 0;

    logic [31:0] op   [ND];
    logic [7:0]  ot   [ND];
    logic        ov   [ND];
    logic        ovld [ND];
    logic        ird  [ND];

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t fifo [ND][256];
    int   wr [ND];
    int   rd [ND];
    int   n_emit [ND];
    logic [31:0] hp [ND];
    logic [7:0]  ht [ND];
    logic        hv [ND];
    bit          hstall [ND];
    int          glat [ND];
    logic [31:0] gp [ND];
    logic [7:0]  gt [ND];
    logic        gv [ND];

    always #5 ap_clk = ~ap_clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        ptcalc_mul_pipe_if #(.A_W(AW_T[g]), .B_W(BW_T[g]), .OUT_W(OW_T[g]), .TAG_W(8)) bus ();

        ptcalc_mul_pipe #(
            .A_W(AW_T[g]), .B_W(BW_T[g]), .OUT_W(OW_T[g]), .SHIFT(SH_T[g]),
            .NUM_STAGE(NS_T[g]), .SIGNED(SG_T[g]), .ROUND(RD_T[g]), .SAT(SA_T[g]), .TAG_W(8)
        ) dut (
            .ap_clk  (ap_clk),
            .ap_rst_n(ap_rst_n),
            .bus     (bus)
        );

        assign bus.in_valid  = in_valid;
        assign bus.in_a      = in_a[AW_T[g]-1:0];
        assign bus.in_b      = in_b[BW_T[g]-1:0];
        assign bus.in_tag    = in_tag;
        assign bus.out_ready = out_ready;
        assign op[g]         = 32'(bus.out_p);
        assign ot[g]         = bus.out_tag;
        assign ov[g]         = bus.out_ovf;
        assign ovld[g]       = bus.out_valid;
        assign ird[g]        = bus.in_ready;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product, floor division for the shift, then clamp or modulo.
    function automatic void model(input int k, input logic [15:0] a, input logic [15:0] b,
                                  output logic [31:0] p, output logic ovf);
        longint one, av, bv, v, d, q, hi, lo, mw, m, w;
        one = 64'sd1;
        av  = longint'({48'd0, a}) & ((one << AW_T[k]) - one);
        bv  = longint'({48'd0, b}) & ((one << BW_T[k]) - one);
        if (SG_T[k] != 0) begin
            if (av >= (one << (AW_T[k] - 1))) av = av - (one << AW_T[k]);
            if (bv >= (one << (BW_T[k] - 1))) bv = bv - (one << BW_T[k]);
        end
        v = av * bv;
        if (SH_T[k] > 0) begin
            d = one << SH_T[k];
            if (RD_T[k] != 0) v = v + d / 2;
            q = v / d;
            if (v < 0 && q * d != v) q = q - one;
            v = q;
        end
        mw = one << OW_T[k];
        if (SG_T[k] != 0) begin
            hi = mw / 2 - one;
            lo = -(mw / 2);
        end else begin
            hi = mw - one;
            lo = 0;
        end
        if (SA_T[k] != 0) begin
            ovf = 1'b1;
            if (v > hi)      w = hi;
            else if (v < lo) w = lo;
            else begin
                w   = v;
                ovf = 1'b0;
            end
            m = w & (mw - one);
        end else begin
            m = v % mw;
            if (m < 0) m = m + mw;
            w = m;
            if (SG_T[k] != 0 && m >= mw / 2) w = m - mw;
            ovf = (w != v);
        end
        p = m[31:0];
    endfunction

    initial forever begin
        @(posedge ap_clk);
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Scoreboard: one in-order expectation queue per DUT, plus handshake and hold checks.
    initial forever begin
        exp_t e;
        @(negedge ap_clk);
        for (int k = 0; k < ND; k++) begin
            if (!ap_rst_n) begin
                rd[k]     = wr[k];
                hstall[k] = 1'b0;
            end else begin
                chk($sformatf("d%0d_in_ready", k), ird[k], !ovld[k] || out_ready);
                if (hstall[k])
                    chk($sformatf("d%0d_hold", k), {ovld[k], op[k], ot[k], ov[k]},
                        {1'b1, hp[k], ht[k], hv[k]});
                if (in_valid && ird[k]) begin
                    model(k, in_a, in_b, e.p, e.ovf);
                    e.tag = in_tag;
                    fifo[k][wr[k] % 256] = e;
                    wr[k]++;
                end
                if (ovld[k] && out_ready) begin
                    n_emit[k]++;
                    if (rd[k] == wr[k]) begin
                        chk($sformatf("d%0d_spurious_out", k), 1, 0);
                    end else begin
                        e = fifo[k][rd[k] % 256];
                        rd[k]++;
                        chk($sformatf("d%0d_tag", k), ot[k], e.tag);
                        chk($sformatf("d%0d_p", k), op[k], e.p);
                        chk($sformatf("d%0d_ovf", k), ov[k], e.ovf);
                    end
                end
                hstall[k] = ovld[k] && !out_ready;
                hp[k] = op[k];
                ht[k] = ot[k];
                hv[k] = ov[k];
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [7:0] tag);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge ap_clk);
            if (ird[0]) done = 1'b1;
            @(posedge ap_clk);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    // One sample into idle pipes; records each DUT's first output and its latency.
    task automatic shot(input logic [15:0] a, input logic [15:0] b, input logic [7:0] tag);
        for (int k = 0; k < ND; k++) glat[k] = -1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int c = 1; c <= 10; c++) begin
            @(posedge ap_clk);
            #1;
            in_valid = 1'b0;
            for (int k = 0; k < ND; k++) begin
                if (glat[k] < 0 && ovld[k]) begin
                    glat[k] = c;
                    gp[k]   = op[k];
                    gt[k]   = ot[k];
                    gv[k]   = ov[k];
                end
            end
        end
        for (int k = 0; k < ND; k++) chk($sformatf("d%0d_latency", k), glat[k], NS_T[k]);
    endtask

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int base;
        #1 ap_rst_n = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("d%0d_rst_valid", k), ovld[k], 0);
            chk($sformatf("d%0d_rst_out", k), {op[k], ot[k], ov[k]}, 0);
        end
        ap_rst_n = 1'b1;
        idle(2);

        shot(16'd1000, 16'd2000, 8'h5A);
        chk("t1_p", gp[0], 32'd2000000);
        chk("t1_tag", gt[0], 8'h5A);
        chk("t1_ovf", gv[0], 0);

        shot(16'hFFFF, 16'hFFFF, 8'h11);
        chk("sat_p", gp[0], 32'h7FFFFFFF);
        chk("sat_ovf", gv[0], 1);
        chk("wrap_p", gp[1], 32'h7FFE0001);
        chk("wrap_ovf", gv[1], 1);

        shot(16'h00FD, 16'h0005, 8'h22);
        chk("signed_p", gp[2], 32'h0000FFF1);
        chk("signed_ovf", gv[2], 0);

        shot(16'd4, 16'd6, 8'h33);
        chk("round24_p", gp[3], 32'd2);
        chk("trunc24_p", gp[4], 32'd1);

        shot(16'd23, 16'd1, 8'h44);
        chk("round23_p", gp[3], 32'd1);

        base = n_emit[0];
        fork
            for (int t = 1; t <= 10; t++) send(16'(t * 997), 16'(t + 100), 8'(t));
            begin
                repeat (4) @(posedge ap_clk);
                rdy_mode = 2;
                repeat (4) @(posedge ap_clk);
                rdy_mode = 0;
            end
        join
        idle(12);
        chk("stream_count", n_emit[0] - base, 10);

        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send(rand_op(), rand_op(), 8'(i));
        end
        idle(1);
        rdy_mode = 0;
        idle(15);
        for (int k = 0; k < ND; k++) chk($sformatf("d%0d_drained", k), wr[k] - rd[k], 0);

        rdy_mode = 2;
        idle(2);
        send(16'd11, 16'd12, 8'hA1);
        send(16'd13, 16'd14, 8'hA2);
        send(16'd15, 16'd16, 8'hA3);
        in_valid = 1'b0;
        #1 ap_rst_n = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) chk($sformatf("d%0d_midrst_valid", k), ovld[k], 0);
        chk("midrst_out", {op[0], ot[0], ov[0]}, 0);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        rdy_mode = 0;
        idle(2);
        shot(16'd300, 16'd7, 8'hC3);
        for (int k = 0; k < ND; k++) chk($sformatf("d%0d_postrst_tag", k), gt[k], 8'hC3);
        chk("postrst_p", gp[0], 32'd2100);
        idle(4);
        for (int k = 0; k < ND; k++) chk($sformatf("d%0d_final_empty", k), wr[k] - rd[k], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
